// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I ALU issue stage with registered operands and captured result
// Two-slot valid/ready pipeline: stage 1 drives the external ALU, stage 2 holds its result.
module alu_issue_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              out_branch,
  output logic              out_taken,
  output logic              out_illegal
);

  localparam logic [CTRL_W-1:0] CTRL_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] CTRL_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] CTRL_SUB = CTRL_W'(4'b0110);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [XLEN-1:0]   dec_a;
  logic [XLEN-1:0]   dec_b;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_br;
  logic              dec_bne;
  logic              dec_ill;

  logic              s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]   alu_a_q, alu_a_d;
  logic [XLEN-1:0]   alu_b_q, alu_b_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              s1_br_q, s1_br_d;
  logic              s1_bne_q, s1_bne_d;
  logic              s1_ill_q, s1_ill_d;

  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic              out_branch_q, out_branch_d;
  logic              out_taken_q, out_taken_d;
  logic              out_illegal_q, out_illegal_d;

  logic adv1, adv2, accept, capture;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec_a    = in_rs1_data;
    dec_b    = in_rs2_data;
    dec_ctrl = CTRL_ADD;
    dec_br   = 1'b0;
    dec_bne  = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000)      dec_ctrl = CTRL_ADD;
            else if (funct7 == 7'b0100000) dec_ctrl = CTRL_SUB;
            else                           dec_ill  = 1'b1;
          end
          3'b111:  dec_ctrl = CTRL_AND;
          3'b110:  dec_ctrl = CTRL_OR;
          default: dec_ill  = 1'b1;
        endcase
      end
      OP_I: begin
        dec_b = in_imm;
        case (funct3)
          3'b000:  dec_ctrl = CTRL_ADD;
          3'b111:  dec_ctrl = CTRL_AND;
          3'b110:  dec_ctrl = CTRL_OR;
          default: dec_ill  = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: dec_b = in_imm;
      OP_BRANCH: begin
        dec_ctrl = CTRL_SUB;
        case (funct3)
          3'b000:  dec_br = 1'b1;
          3'b001: begin
            dec_br  = 1'b1;
            dec_bne = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal ops still flow through the ALU, so keep it on a defined code with zero operands.
    if (dec_ill) begin
      dec_a    = '0;
      dec_b    = '0;
      dec_ctrl = CTRL_ADD;
      dec_br   = 1'b0;
      dec_bne  = 1'b0;
    end
  end

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign accept   = in_valid && adv1;
  assign capture  = adv2 && s1_valid_q;
  assign in_ready = adv1;

  always_comb begin
    s1_valid_d = adv1 ? in_valid : s1_valid_q;
    alu_a_d    = accept ? dec_a    : alu_a_q;
    alu_b_d    = accept ? dec_b    : alu_b_q;
    alu_ctrl_d = accept ? dec_ctrl : alu_ctrl_q;
    s1_br_d    = accept ? dec_br   : s1_br_q;
    s1_bne_d   = accept ? dec_bne  : s1_bne_q;
    s1_ill_d   = accept ? dec_ill  : s1_ill_q;

    out_valid_d   = adv2 ? s1_valid_q : out_valid_q;
    out_result_d  = out_result_q;
    out_branch_d  = out_branch_q;
    out_taken_d   = out_taken_q;
    out_illegal_d = out_illegal_q;
    if (capture) begin
      out_result_d  = s1_ill_q ? '0 : alu_result;
      out_branch_d  = s1_br_q;
      out_taken_d   = s1_br_q && (alu_zero ^ s1_bne_q);
      out_illegal_d = s1_ill_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctrl_q    <= CTRL_ADD;
      s1_br_q       <= 1'b0;
      s1_bne_q      <= 1'b0;
      s1_ill_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_branch_q  <= 1'b0;
      out_taken_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_ctrl_q    <= alu_ctrl_d;
      s1_br_q       <= s1_br_d;
      s1_bne_q      <= s1_bne_d;
      s1_ill_q      <= s1_ill_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_branch_q  <= out_branch_d;
      out_taken_q   <= out_taken_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_branch  = out_branch_q;
  assign out_taken   = out_taken_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized and directed bench for alu_issue_stage
// Reference model: two abstract pipeline slots holding architecturally computed results.
module tb_alu_issue_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_branch;
  logic        out_taken;
  logic        out_illegal;

  int vectors = 0;
  int fails   = 0;

  alu_issue_stage #(.XLEN(32), .CTRL_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_branch(out_branch), .out_taken(out_taken), .out_illegal(out_illegal)
  );

  // Combinational ALU the stage drives.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_ctrl == 4'b0110) && (alu_a == alu_b);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        br;
    logic        tk;
    logic        ill;
  } rec_t;

  rec_t m_s1, m_s2;
  bit   m_v1, m_v2;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    logic [4:0] rs2f, rs1f, rdf;
    rs2f = 5'($urandom);
    rs1f = 5'($urandom);
    rdf  = 5'($urandom);
    return {f7, rs2f, rs1f, f3, rdf, op};
  endfunction

  // Architectural meaning of each instruction, written as plain arithmetic.
  function automatic rec_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] im);
    rec_t r;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    r.a = r1; r.b = r2; r.ctrl = 4'b0010; r.res = 32'd0; r.br = 1'b0; r.tk = 1'b0; r.ill = 1'b0;
    if (op == OP_R && f3 == 3'b000 && f7 == 7'b0000000) r.res = r1 + r2;
    else if (op == OP_R && f3 == 3'b000 && f7 == 7'b0100000) begin r.ctrl = 4'b0110; r.res = r1 - r2; end
    else if (op == OP_R && f3 == 3'b111) begin r.ctrl = 4'b0000; r.res = r1 & r2; end
    else if (op == OP_R && f3 == 3'b110) begin r.ctrl = 4'b0001; r.res = r1 | r2; end
    else if (op == OP_I && f3 == 3'b000) begin r.b = im; r.res = r1 + im; end
    else if (op == OP_I && f3 == 3'b111) begin r.b = im; r.ctrl = 4'b0000; r.res = r1 & im; end
    else if (op == OP_I && f3 == 3'b110) begin r.b = im; r.ctrl = 4'b0001; r.res = r1 | im; end
    else if (op == OP_LD || op == OP_ST) begin r.b = im; r.res = r1 + im; end
    else if (op == OP_BR && (f3 == 3'b000 || f3 == 3'b001)) begin
      r.ctrl = 4'b0110;
      r.res  = r1 - r2;
      r.br   = 1'b1;
      r.tk   = (f3 == 3'b000) ? (r1 == r2) : (r1 != r2);
    end else begin
      r.a = 32'd0; r.b = 32'd0; r.ill = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(m_v2));
    if (m_v2) begin
      chk("out_result", out_result, m_s2.res);
      chk("out_branch", 32'(out_branch), 32'(m_s2.br));
      chk("out_taken", 32'(out_taken), 32'(m_s2.tk));
      chk("out_illegal", 32'(out_illegal), 32'(m_s2.ill));
    end
    if (m_v1) begin
      chk("alu_a", alu_a, m_s1.a);
      chk("alu_b", alu_b, m_s1.b);
      chk("alu_ctrl", 32'(alu_ctrl), 32'(m_s1.ctrl));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after checking outputs.
  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input bit ordy);
    bit exp_rdy;
    rec_t r;
    in_valid = iv; in_instr = ins; in_rs1_data = r1; in_rs2_data = r2; in_imm = im; out_ready = ordy;
    #1;
    exp_rdy = !(m_v1 && m_v2) || ordy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    r = model(ins, r1, r2, im);
    if (!m_v2 || ordy) begin
      m_s2 = m_s1; m_v2 = m_v1; m_v1 = 1'b0;
    end
    if (iv && exp_rdy) begin
      m_s1 = r; m_v1 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, ordy);
  endtask

  initial begin
    logic [31:0] ins, r1, r2, im;
    logic [2:0]  f3;
    logic [6:0]  f7;
    bit          ordy;
    m_v1 = 1'b0; m_v2 = 1'b0;
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_rs1_data = 32'd0;
    in_rs2_data = 32'd0; in_imm = 32'd0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd2);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Latency: ADD 5+7
    cycle(1'b1, enc(7'h00, 3'b000, OP_R), 32'd5, 32'd7, 32'd0, 1'b1);
    chk("t1_alu_ctrl", 32'(alu_ctrl), 32'd2);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
    idle(1'b1);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_result", out_result, 32'd12);

    // SUB and ORI
    cycle(1'b1, enc(7'h20, 3'b000, OP_R), 32'd3, 32'd10, 32'd0, 1'b1);
    cycle(1'b1, enc(7'h00, 3'b110, OP_I), 32'hF0, 32'd99, 32'h0F, 1'b1);
    chk("t2_sub", out_result, 32'hFFFF_FFF9);
    chk("t2_sub_branch", 32'(out_branch), 32'd0);
    idle(1'b1);
    chk("t2_ori", out_result, 32'hFF);

    // Branches
    cycle(1'b1, enc(7'h00, 3'b000, OP_BR), 32'h1234, 32'h1234, 32'd0, 1'b1);
    cycle(1'b1, enc(7'h00, 3'b001, OP_BR), 32'h1234, 32'h1234, 32'd0, 1'b1);
    chk("t3_beq_taken", 32'(out_taken), 32'd1);
    chk("t3_beq_result", out_result, 32'd0);
    cycle(1'b1, enc(7'h00, 3'b001, OP_BR), 32'd1, 32'd2, 32'd0, 1'b1);
    chk("t3_bne_eq_taken", 32'(out_taken), 32'd0);
    idle(1'b1);
    chk("t3_bne_ne_taken", 32'(out_taken), 32'd1);
    idle(1'b1);

    // Backpressure: three ADDs with out_ready low
    cycle(1'b1, enc(7'h00, 3'b000, OP_R), 32'd1, 32'd1, 32'd0, 1'b0);
    cycle(1'b1, enc(7'h00, 3'b000, OP_R), 32'd2, 32'd2, 32'd0, 1'b0);
    chk("t4_in_ready_low", 32'(in_ready), 32'd0);
    chk("t4_first", out_result, 32'd2);
    cycle(1'b1, enc(7'h00, 3'b000, OP_R), 32'd3, 32'd3, 32'd0, 1'b0);
    chk("t4_hold", out_result, 32'd2);
    cycle(1'b1, enc(7'h00, 3'b000, OP_R), 32'd3, 32'd3, 32'd0, 1'b1);
    chk("t4_second", out_result, 32'd4);
    idle(1'b1);
    chk("t4_third", out_result, 32'd6);
    idle(1'b1);
    chk("t4_drained", 32'(out_valid), 32'd0);

    // Illegal XOR, then a legal op
    cycle(1'b1, enc(7'h00, 3'b100, OP_R), 32'hDEAD, 32'hBEEF, 32'd0, 1'b1);
    chk("t5_alu_ctrl", 32'(alu_ctrl), 32'd2);
    cycle(1'b1, enc(7'h00, 3'b111, OP_R), 32'hFF00, 32'h0FF0, 32'd0, 1'b1);
    chk("t5_illegal", 32'(out_illegal), 32'd1);
    chk("t5_result", out_result, 32'd0);
    idle(1'b1);
    chk("t5_next_legal", out_result, 32'h0F00);
    chk("t5_next_flag", 32'(out_illegal), 32'd0);

    // Reset with both stages full
    cycle(1'b1, enc(7'h00, 3'b000, OP_R), 32'd9, 32'd9, 32'd0, 1'b0);
    cycle(1'b1, enc(7'h20, 3'b000, OP_R), 32'd8, 32'd1, 32'd0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_alu_ctrl", 32'(alu_ctrl), 32'd2);
    m_v1 = 1'b0; m_v2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(1'b1);
    idle(1'b1);
    cycle(1'b1, enc(7'h00, 3'b000, OP_R), 32'd1, 32'd1, 32'd0, 1'b1);
    idle(1'b1);
    chk("t6_add", out_result, 32'd2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      im = $urandom;
      f3 = 3'($urandom);
      case ($urandom_range(0, 2))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 6))
        0, 1:    ins = enc(f7, f3, OP_R);
        2:       ins = enc(f7, f3, OP_I);
        3:       ins = enc(f7, f3, OP_LD);
        4:       ins = enc(f7, f3, OP_ST);
        5:       ins = enc(f7, 3'($urandom_range(0, 2)), OP_BR);
        default: ins = enc(f7, f3, 7'($urandom));
      endcase
      ordy = ($urandom_range(0, 9) < 7);
      cycle(($urandom_range(0, 3) != 0), ins, r1, r2, im, ordy);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
